// File: rtl/digit_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output glyph ROM among NREQ text fields.
// Tags follow each read through the ROM latency so the colour returns to its owner.
`ifndef WARNING
`define WARNING 12'hF00
`endif

module digit_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [6*NREQ-1:0]   req_x,
    input  logic [3*NREQ-1:0]   req_y,
    input  logic [4*NREQ-1:0]   req_digit,
    output logic [NREQ-1:0]     gnt,
    output logic [5:0]          rom_x,
    output logic [2:0]          rom_y,
    output logic [3:0]          rom_a0,
    input  logic [11:0]         rom_color,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [11:0]         rsp_color,
    output logic                rsp_warn,
    output logic                busy
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0]              r_ptr;
    logic [ROM_LAT:0]           r_vld;
    logic [ROM_LAT:0][PW-1:0]   r_id;

    logic [2*NREQ-1:0]          w_dbl;
    logic [NREQ-1:0]            w_rot;
    logic [NREQ-1:0]            w_gnt;
    logic [PW-1:0]              w_off;
    logic [PW-1:0]              w_idx;
    logic [PW:0]                w_sum;
    logic                       w_any;
    logic [5:0]                 w_x;
    logic [2:0]                 w_y;
    logic [3:0]                 w_d;

    always_comb begin
        w_dbl = {req, req} >> r_ptr;
        // Low half is req rotated by ptr; the high half is a subset of it, so OR-ing is harmless.
        w_rot = w_dbl[NREQ-1:0] | w_dbl[2*NREQ-1:NREQ];
        w_any = |w_rot;
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = PW'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
        w_idx = w_sum[PW-1:0];

        w_gnt = '0;
        w_x   = '0;
        w_y   = '0;
        w_d   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_any && (w_idx == PW'(k))) begin
                w_gnt[k] = 1'b1;
                w_x      = req_x[6*k +: 6];
                w_y      = req_y[3*k +: 3];
                w_d      = req_digit[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            rom_x  <= '0;
            rom_y  <= '0;
            rom_a0 <= '0;
            r_vld  <= '0;
            r_id   <= '0;
        end else begin
            r_vld[0] <= w_any;
            r_id[0]  <= w_idx;
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_id[s]  <= r_id[s-1];
            end
            if (w_any) begin
                r_ptr  <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
                rom_x  <= w_x;
                rom_y  <= w_y;
                rom_a0 <= w_d;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_vld[ROM_LAT] && (r_id[ROM_LAT] == PW'(k))) rsp_valid[k] = 1'b1;
        end
    end

    assign gnt       = w_gnt;
    assign rsp_color = rom_color;
    assign rsp_warn  = r_vld[ROM_LAT] && (rom_color == `WARNING);
    assign busy      = |r_vld;

endmodule

// File: tb/tb_digit_rom_arbiter.sv
// Directed bench for digit_rom_arbiter: a ROM_LAT=1 instance for the main sequence and a
// ROM_LAT=2 instance for the latency check, each with its own behavioural glyph ROM.
`ifndef WARNING
`define WARNING 12'hF00
`endif

module tb_digit_rom_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req,  req2;
    logic [23:0] req_x, req_x2;
    logic [11:0] req_y, req_y2;
    logic [15:0] req_digit, req_digit2;
    logic [3:0]  gnt, gnt2;
    logic [5:0]  rom_x, rom_x2;
    logic [2:0]  rom_y, rom_y2;
    logic [3:0]  rom_a0, rom_a02;
    logic [11:0] rom_color, rom_color2, q2a;
    logic [3:0]  rsp_valid, rsp_valid2;
    logic [11:0] rsp_color, rsp_color2;
    logic        rsp_warn, rsp_warn2;
    logic        busy, busy2;

    int checks = 0;
    int errors = 0;

    digit_rom_arbiter #(.NREQ(4), .ROM_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .req_digit(req_digit), .gnt(gnt), .rom_x(rom_x), .rom_y(rom_y),
        .rom_a0(rom_a0), .rom_color(rom_color), .rsp_valid(rsp_valid),
        .rsp_color(rsp_color), .rsp_warn(rsp_warn), .busy(busy)
    );

    digit_rom_arbiter #(.NREQ(4), .ROM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_x(req_x2), .req_y(req_y2),
        .req_digit(req_digit2), .gnt(gnt2), .rom_x(rom_x2), .rom_y(rom_y2),
        .rom_a0(rom_a02), .rom_color(rom_color2), .rsp_valid(rsp_valid2),
        .rsp_color(rsp_color2), .rsp_warn(rsp_warn2), .busy(busy2)
    );

    function automatic logic [11:0] rom_f(input logic [5:0] x, input logic [2:0] y,
                                          input logic [3:0] d);
        if (x > 6'd13) return `WARNING;
        return {d, 1'b1, y, x[3:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural glyph ROMs: one and two registered stages.
    always @(posedge clk) begin
        rom_color  <= rom_f(rom_x, rom_y, rom_a0);
        q2a        <= rom_f(rom_x2, rom_y2, rom_a02);
        rom_color2 <= q2a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_slot(input int i, input logic [5:0] x, input logic [2:0] y,
                            input logic [3:0] d);
        req_x[6*i +: 6]     = x;
        req_y[3*i +: 3]     = y;
        req_digit[4*i +: 4] = d;
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req_x = '0; req_y = '0; req_digit = '0;
        req2 = '0; req_x2 = '0; req_y2 = '0; req_digit2 = '0;
        tick();
        tick();
        check("rst_gnt",   gnt,       0);
        check("rst_rom_x", rom_x,     0);
        check("rst_rom_a", rom_a0,    0);
        check("rst_rsp",   rsp_valid, 0);
        check("rst_warn",  rsp_warn,  0);
        check("rst_busy",  busy,      0);
        #2 rst = 1'b0;

        // Single read, slot 0
        tick();
        req = 4'b0001; set_slot(0, 6'd0, 3'd2, 4'd1);
        settle();
        check("t1_gnt",  gnt,  4'b0001);
        check("t1_busy0", busy, 0);
        tick();
        req = 4'b0000;
        settle();
        check("t1_gnt_off", gnt,    0);
        check("t1_rom_x",   rom_x,  0);
        check("t1_rom_y",   rom_y,  2);
        check("t1_rom_a0",  rom_a0, 1);
        check("t1_busy1",   busy,   1);
        check("t1_rsp_early", rsp_valid, 0);
        tick(); settle();
        check("t1_rsp",   rsp_valid, 4'b0001);
        check("t1_color", rsp_color, rom_f(6'd0, 3'd2, 4'd1));
        check("t1_busy2", busy, 1);
        check("t1_warn",  rsp_warn, 0);
        tick(); settle();
        check("t1_busy3", busy, 0);
        check("t1_rsp_off", rsp_valid, 0);

        // Full load from ptr = 0 (re-reset so the pointer starts at slot 0)
        rst = 1'b1; #2 rst = 1'b0;
        for (int s = 0; s < 4; s++) set_slot(s, 6'(s), 3'(s), 4'(s + 2));
        for (int k = 0; k < 10; k++) begin
            tick();
            req = (k < 8) ? 4'b1111 : 4'b0000;
            settle();
            check("t2_gnt", gnt, (k < 8) ? (1 << (k % 4)) : 0);
            if (k >= 2) begin
                check("t2_rsp",   rsp_valid, 1 << ((k - 2) % 4));
                check("t2_color", rsp_color, rom_f(6'((k - 2) % 4), 3'((k - 2) % 4),
                                                   4'(((k - 2) % 4) + 2)));
            end else begin
                check("t2_rsp_idle", rsp_valid, 0);
            end
        end

        // Wrap: grant slot 2 so ptr = 3, then slots 3 and 0 compete
        tick();
        req = 4'b0100;
        settle();
        check("t3_gnt2", gnt, 4'b0100);
        tick();
        req = 4'b1001;
        settle();
        check("t3_gnt3", gnt, 4'b1000);
        tick();
        req = 4'b0001;
        settle();
        check("t3_gnt0", gnt, 4'b0001);
        check("t3_rsp2", rsp_valid, 4'b0100);
        tick();
        req = 4'b0000;
        settle();
        check("t3_gnt_off", gnt, 0);
        check("t3_rsp3", rsp_valid, 4'b1000);
        tick(); settle();
        check("t3_rsp0", rsp_valid, 4'b0001);
        tick(); settle();
        check("t3_idle", busy, 0);

        // Invalid operands on slot 1 (ptr = 1)
        tick();
        req = 4'b0010; set_slot(1, 6'd20, 3'd5, 4'd12);
        settle();
        check("t4_gnt", gnt, 4'b0010);
        tick();
        req = 4'b0000;
        settle();
        check("t4_rom_x",  rom_x,  20);
        check("t4_rom_a0", rom_a0, 12);
        check("t4_warn_early", rsp_warn, 0);
        tick(); settle();
        check("t4_rsp",   rsp_valid, 4'b0010);
        check("t4_color", rsp_color, `WARNING);
        check("t4_warn",  rsp_warn, 1);
        tick(); settle();
        check("t4_warn_off", rsp_warn, 0);
        check("t4_rsp_off",  rsp_valid, 0);

        // Single requester held high, slot 0 (ptr = 2)
        set_slot(0, 6'd7, 3'd6, 4'd9);
        for (int k = 0; k < 6; k++) begin
            tick();
            req = (k < 3) ? 4'b0001 : 4'b0000;
            settle();
            check("t5_gnt", gnt, (k < 3) ? 4'b0001 : 4'b0000);
            check("t5_rsp", rsp_valid, (k >= 2 && k < 5) ? 4'b0001 : 4'b0000);
            if (k >= 2 && k < 5) check("t5_color", rsp_color, rom_f(6'd7, 3'd6, 4'd9));
        end

        // Reset in the middle of two in-flight reads (ptr = 1)
        set_slot(1, 6'd3, 3'd1, 4'd4);
        set_slot(2, 6'd4, 3'd2, 4'd5);
        set_slot(3, 6'd5, 3'd3, 4'd6);
        tick();
        req = 4'b0010;
        settle();
        check("t6_gnt1", gnt, 4'b0010);
        tick();
        req = 4'b0100;
        settle();
        check("t6_gnt2", gnt, 4'b0100);
        rst = 1'b1;
        req = 4'b0000;
        settle();
        check("t6_rst_gnt",  gnt,       0);
        check("t6_rst_x",    rom_x,     0);
        check("t6_rst_a0",   rom_a0,    0);
        check("t6_rst_busy", busy,      0);
        check("t6_rst_rsp",  rsp_valid, 0);
        #2 rst = 1'b0;
        tick(); settle();
        check("t6_rsp_T2", rsp_valid, 0);
        check("t6_busy_T2", busy, 0);
        tick();
        req = 4'b1100;
        settle();
        check("t6_rsp_T3", rsp_valid, 0);
        check("t6_gnt_ptr0", gnt, 4'b0100);
        tick();
        req = 4'b1000;
        settle();
        check("t6_gnt3", gnt, 4'b1000);
        tick();
        req = 4'b0000;
        settle();
        check("t6_rsp2", rsp_valid, 4'b0100);
        check("t6_color2", rsp_color, rom_f(6'd4, 3'd2, 4'd5));
        tick(); settle();
        check("t6_rsp3", rsp_valid, 4'b1000);

        // ROM_LAT = 2 instance
        tick();
        req2 = 4'b0001;
        req_x2[5:0] = 6'd5; req_y2[2:0] = 3'd3; req_digit2[3:0] = 4'd7;
        settle();
        check("t7_gnt", gnt2, 4'b0001);
        tick();
        req2 = 4'b0000;
        settle();
        check("t7_rsp_T1", rsp_valid2, 0);
        check("t7_busy_T1", busy2, 1);
        tick(); settle();
        check("t7_rsp_T2", rsp_valid2, 0);
        check("t7_busy_T2", busy2, 1);
        tick(); settle();
        check("t7_rsp_T3", rsp_valid2, 4'b0001);
        check("t7_color",  rsp_color2, rom_f(6'd5, 3'd3, 4'd7));
        tick(); settle();
        check("t7_rsp_off", rsp_valid2, 0);
        check("t7_busy_off", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_rom_arbiter.md
Name: digit_rom_arbiter

Overview:
- Shares one digit1_rom glyph instance (digit + 's' glyph, 14 columns x 8 rows, one-cycle registered colour output) among NREQ on-screen text fields, e.g. timer, score and countdown.
- Each requester presents a glyph coordinate and digit and holds it until granted. The arbiter grants round-robin, drives the ROM address, and tracks in-flight reads with a tag pipeline. It returns the colour to the owning requester with a one-hot valid strobe.
- Sits between the VGA overlay field generators and the ROM.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ROM_LAT, 1, clock cycles from the ROM address changing to the matching colour appearing on rom_color.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  request per field; held high with its operands stable until the matching gnt bit.
- req_x  in  6*NREQ  packed glyph column; slot i is bits [6i+5:6i].
- req_y  in  3*NREQ  packed glyph row; slot i is bits [3i+2:3i].
- req_digit  in  4*NREQ  packed digit value; slot i is bits [4i+3:4i].
- gnt  out  NREQ  one-hot grant; combinational in the accept cycle.
- rom_x  out  6  registered ROM column.
- rom_y  out  3  registered ROM row.
- rom_a0  out  4  registered ROM digit.
- rom_color  in  12  ROM colour output.
- rsp_valid  out  NREQ  one-hot response strobe.
- rsp_color  out  12  response colour; equals rom_color, meaningful only while rsp_valid != 0.
- rsp_warn  out  1  high when a response is valid and rsp_color == `WARNING (glyph column x > 13).
- busy  out  1  high while any read is in flight.

Behaviour:
Reset values:
- gnt, rsp_valid, rsp_warn and busy are 0.
- rom_x, rom_y and rom_a0 are 0.
- The round-robin pointer ptr is 0, and every pipeline valid bit is cleared.

Arbitration, cycle T:
- Search req starting at index ptr, ascending, wrapping at NREQ-1 to 0. The first set bit i wins.
- gnt = (1<<i) in cycle T. gnt = 0 when req == 0.
- One grant at most per cycle. A request is accepted on every cycle that any req bit is high; there is no back-pressure.
- At the clock edge ending T:
  - ptr <= (i+1) mod NREQ.
  - rom_x, rom_y and rom_a0 load slot i's operands.
  - Stage-0 tag gets valid = 1 and id = i.
- With no grant: ptr, rom_x, rom_y and rom_a0 hold their values, and stage-0 valid <= 0.

Tag pipeline:
- ROM_LAT+1 registered stages of {valid, id}, each advancing every cycle with no stalls.
- The last stage aligns with the rom_color for its address: the address registers in T+1, and the colour arrives in T+1+ROM_LAT.
- Total latency is ROM_LAT+1 cycles from gnt to response. The default is a grant in T and rsp_valid in T+2.
- rsp_valid = valid_last ? (1<<id_last) : 0, and rsp_color = rom_color (pass-through).
- rsp_warn = valid_last && (rom_color == `WARNING).
- busy = OR of all tag-stage valid bits.

Boundary conditions:
- Full sustained load, all req high: the grants cycle 0,1,...,NREQ-1,0 with one response per cycle and no bubbles.
- A requester that drops req before being granted is not granted and produces no response.
- A requester re-requesting in the cycle after its grant is allowed. It is served after the others already requesting, per the pointer.
- Single requester held high: granted every cycle, and its responses stream back-to-back.
- Wrap-around: with ptr = NREQ-1 and requests at NREQ-1 and 0, NREQ-1 wins, then 0.
- Reset asserted mid-operation: all in-flight reads are discarded, and outputs take their reset values asynchronously. No rsp_valid pulse appears for reads issued before reset.
- Invalid operands (x > 13, digit > 9) are passed through unchanged. The ROM's output is returned, and rsp_warn flags the `WARNING colour.

Test Plan:
- Reset, then req = 4'b0001 with x = 0, y = 2, digit = 1 for one cycle -> gnt = 0001 in the same cycle; rom_x = 0, rom_a0 = 1 the next cycle; rsp_valid = 0001 two cycles after the grant, with rsp_color equal to the model ROM output; busy high for 2 cycles.
- req = 4'b1111 held for 8 cycles -> gnt sequence 1,2,4,8,1,2,4,8; rsp_valid reproduces the same sequence delayed 2 cycles; no idle cycles.
- ptr = 3 (after a grant to slot 2), then req = 4'b1001 -> slot 3 granted, then slot 0; wrap verified.
- Slot 1 requests with x = 20 -> rsp_valid = 0010, rsp_color = `WARNING, rsp_warn = 1 in the response cycle only.
- Grants issued in cycles T and T+1, rst pulsed in T+1 -> all outputs 0 immediately; no rsp_valid in T+2 or T+3; after release, the first req = 0100 is granted with ptr = 0 ordering.
- ROM_LAT = 2 build, single request -> rsp_valid appears 3 cycles after gnt, aligned with the delayed ROM model colour.
